// File: rtl/note_window_sequencer_if.sv
// Song ROM read bus: registered address out of the sequencer, data back from the ROM.
// The ROM answers ROM_LAT cycles after the address changes.
interface note_window_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int NOTE_W = 7
);
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_window_sequencer.sv
// Streams song notes from ROM into a WINDOW-deep look-ahead register for the display,
// advancing on a timer (PLAY) or once the player holds the head note (LEARN).
module note_window_sequencer #(
    parameter int NOTE_W      = 7,
    parameter int WINDOW      = 5,
    parameter int ADDR_W      = 10,
    parameter int SONG_BITS   = 2,
    parameter int SONG_STRIDE = 250,
    parameter int NOTE_TICKS  = 25_000_000,
    parameter int HOLD_TICKS  = 2_500_000,
    parameter int ROM_LAT     = 1,
    parameter int SCORE_W     = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic                     learn_mode,
    input  logic [SONG_BITS-1:0]     song_choice,
    input  logic                     pause,
    input  logic [NOTE_W-1:0]        input_note,
    input  logic                     input_valid,
    note_window_sequencer_if.master  rom_bus,
    output logic [WINDOW*NOTE_W-1:0] notes,
    output logic                     shifting_out,
    output logic                     busy,
    output logic                     finished,
    output logic [SCORE_W-1:0]       hit_count
);
    localparam int TICK_W = $clog2(NOTE_TICKS + 1);
    localparam int ST_W   = $clog2(HOLD_TICKS + 1);
    localparam int LAT_W  = $clog2(ROM_LAT + 1);
    localparam int PC_W   = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_FINISH} state_t;

    state_t                  state_reg;
    logic                    mode_reg;
    logic [ADDR_W-1:0]       rom_addr_reg;
    logic [WINDOW*NOTE_W-1:0] notes_reg;
    logic                    shifting_reg;
    logic                    busy_reg;
    logic                    finished_reg;
    logic [SCORE_W-1:0]      hit_count_reg;
    logic [TICK_W-1:0]       tick_reg;
    logic [ST_W-1:0]         streak_reg;
    logic                    hit_flag_reg;
    logic [LAT_W-1:0]        lat_reg;
    logic [PC_W-1:0]         prime_cnt_reg;

    logic [ADDR_W-1:0]        base_addr;
    logic [WINDOW*NOTE_W-1:0] window_next;
    logic [NOTE_W-1:0]        head;
    logic                     head_is_finish;
    logic                     match;
    logic                     streak_reaches;
    logic                     run_active;
    logic                     play_shift;
    logic                     learn_shift;
    logic                     run_shift;
    logic                     score_next;

    assign base_addr = ADDR_W'(32'(song_choice) * 32'(SONG_STRIDE));

    // New note enters at the LSB end; the oldest note drifts up to the head slot.
    genvar gi;
    generate
        for (gi = 0; gi < WINDOW; gi++) begin : g_window
            if (gi == 0) begin : g_tail
                assign window_next[NOTE_W-1:0] = rom_bus.rom_data;
            end else begin : g_body
                assign window_next[gi*NOTE_W +: NOTE_W] = notes_reg[(gi-1)*NOTE_W +: NOTE_W];
            end
        end
    endgenerate

    assign head           = notes_reg[WINDOW*NOTE_W-1 -: NOTE_W];
    assign head_is_finish = (head == {NOTE_W{1'b1}});
    assign match          = input_valid && (input_note == head);
    assign streak_reaches = match && (streak_reg == ST_W'(HOLD_TICKS - 1));
    // A FINISH head blocks every shift, so it can never be scored.
    assign run_active     = (state_reg == ST_RUN) && !pause && !head_is_finish;
    assign play_shift     = run_active && !mode_reg && (tick_reg == TICK_W'(NOTE_TICKS - 1));
    assign learn_shift    = run_active && mode_reg && hit_flag_reg;
    assign run_shift      = play_shift || learn_shift;
    assign score_next     = learn_shift || (play_shift && (hit_flag_reg || streak_reaches));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= 1'b0;
            rom_addr_reg  <= '0;
            notes_reg     <= '0;
            shifting_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            finished_reg  <= 1'b0;
            hit_count_reg <= '0;
            tick_reg      <= '0;
            streak_reg    <= '0;
            hit_flag_reg  <= 1'b0;
            lat_reg       <= '0;
            prime_cnt_reg <= '0;
        end else begin
            shifting_reg <= 1'b0;
            if (start) begin
                state_reg     <= ST_PRIME;
                mode_reg      <= learn_mode;
                rom_addr_reg  <= base_addr;
                notes_reg     <= '0;
                busy_reg      <= 1'b1;
                finished_reg  <= 1'b0;
                hit_count_reg <= '0;
                tick_reg      <= '0;
                streak_reg    <= '0;
                hit_flag_reg  <= 1'b0;
                lat_reg       <= '0;
                prime_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_PRIME: begin
                        if (lat_reg == LAT_W'(ROM_LAT)) begin
                            lat_reg      <= '0;
                            notes_reg    <= window_next;
                            rom_addr_reg <= rom_addr_reg + 1'b1;
                            shifting_reg <= 1'b1;
                            if (prime_cnt_reg == PC_W'(WINDOW - 1)) begin
                                prime_cnt_reg <= '0;
                                state_reg     <= ST_RUN;
                            end else begin
                                prime_cnt_reg <= prime_cnt_reg + 1'b1;
                            end
                        end else begin
                            lat_reg <= lat_reg + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (head_is_finish) begin
                            state_reg    <= ST_FINISH;
                            busy_reg     <= 1'b0;
                            finished_reg <= 1'b1;
                        end else if (run_shift) begin
                            notes_reg    <= window_next;
                            rom_addr_reg <= rom_addr_reg + 1'b1;
                            shifting_reg <= 1'b1;
                            tick_reg     <= '0;
                            streak_reg   <= '0;
                            hit_flag_reg <= 1'b0;
                            if (score_next && (hit_count_reg != {SCORE_W{1'b1}})) begin
                                hit_count_reg <= hit_count_reg + 1'b1;
                            end
                        end else if (!pause) begin
                            if (match) begin
                                if (streak_reg != ST_W'(HOLD_TICKS)) begin
                                    streak_reg <= streak_reg + 1'b1;
                                end
                            end else begin
                                streak_reg <= '0;
                            end
                            if (streak_reaches) begin
                                hit_flag_reg <= 1'b1;
                            end
                            if (!mode_reg) begin
                                tick_reg <= tick_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rom_bus.rom_addr = rom_addr_reg;
    assign notes            = notes_reg;
    assign shifting_out     = shifting_reg;
    assign busy             = busy_reg;
    assign finished         = finished_reg;
    assign hit_count        = hit_count_reg;
endmodule

// File: tb/tb_note_window_sequencer.sv
// Directed bench for note_window_sequencer: a table of per-phase vectors plus
// hand-written sequences for finish, restart and asynchronous reset.
module tb_note_window_sequencer;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start;
    logic        learn_mode;
    logic [1:0]  song_choice;
    logic        pause;
    logic [6:0]  input_note;
    logic        input_valid;
    logic [20:0] notes;
    logic        shifting_out;
    logic        busy;
    logic        finished;
    logic [11:0] hit_count;

    int total = 0;
    int bad   = 0;

    logic [6:0] rom_mem [0:1023];

    note_window_sequencer_if #(.ADDR_W(10), .NOTE_W(7)) rom_bus ();

    note_window_sequencer #(
        .NOTE_W(7), .WINDOW(3), .ADDR_W(10), .SONG_BITS(2), .SONG_STRIDE(250),
        .NOTE_TICKS(8), .HOLD_TICKS(3), .ROM_LAT(1), .SCORE_W(12)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (start),
        .learn_mode  (learn_mode),
        .song_choice (song_choice),
        .pause       (pause),
        .input_note  (input_note),
        .input_valid (input_valid),
        .rom_bus     (rom_bus),
        .notes       (notes),
        .shifting_out(shifting_out),
        .busy        (busy),
        .finished    (finished),
        .hit_count   (hit_count)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

    typedef struct {
        logic        st;
        logic        lm;
        logic [1:0]  sg;
        logic        pz;
        logic        vl;
        logic [6:0]  nt;
        int          reps;
        int          exp_shifts;
        logic [9:0]  exp_addr;
        logic [20:0] exp_notes;
        logic [11:0] exp_hits;
        logic        exp_busy;
        logic        exp_fin;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] n3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        return {a, b, c};
    endfunction

    function automatic vec_t mk(input logic st, input logic lm, input logic [1:0] sg,
                                input logic pz, input logic vl, input logic [6:0] nt,
                                input int reps, input int sh, input logic [9:0] ad,
                                input logic [20:0] nts, input logic [11:0] hc,
                                input logic bz, input logic fn);
        vec_t v;
        v.st = st; v.lm = lm; v.sg = sg; v.pz = pz; v.vl = vl; v.nt = nt;
        v.reps = reps; v.exp_shifts = sh; v.exp_addr = ad; v.exp_notes = nts;
        v.exp_hits = hc; v.exp_busy = bz; v.exp_fin = fn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int n, output int shifts);
        shifts = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (shifting_out) shifts++;
            start = 1'b0;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        int shifts;
        start = v.st; learn_mode = v.lm; song_choice = v.sg;
        pause = v.pz; input_valid = v.vl; input_note = v.nt;
        run(v.reps, shifts);
        chk($sformatf("row%0d shifts", idx), shifts, v.exp_shifts);
        chk($sformatf("row%0d rom_addr", idx), 32'(rom_bus.rom_addr), 32'(v.exp_addr));
        chk($sformatf("row%0d notes", idx), 32'(notes), 32'(v.exp_notes));
        chk($sformatf("row%0d hit_count", idx), 32'(hit_count), 32'(v.exp_hits));
        chk($sformatf("row%0d busy", idx), 32'(busy), 32'(v.exp_busy));
        chk($sformatf("row%0d finished", idx), 32'(finished), 32'(v.exp_fin));
        $display("row %0d: reps=%0d shifts=%0d addr=%0d notes=%h hits=%0d busy=%0d fin=%0d",
                 idx, v.reps, shifts, rom_bus.rom_addr, notes, hit_count, busy, finished);
    endtask

    initial begin
        int sh;
        for (int k = 0; k < 1024; k++) rom_mem[k] = 7'(k);
        rst_in = 1'b0; start = 1'b0; learn_mode = 1'b0; song_choice = 2'd0;
        pause = 1'b0; input_note = 7'd0; input_valid = 1'b0;

        // Test 1: prime song 1 in PLAY, then first timed shift
        vecs.push_back(mk(1,0,1,0,0,7'h00, 1,0,250, 21'h0,                 0,1,0));
        vecs.push_back(mk(0,0,1,0,0,7'h00, 6,3,253, n3(7'h7A,7'h7B,7'h7C), 0,1,0));
        vecs.push_back(mk(0,0,1,0,0,7'h00, 7,0,253, n3(7'h7A,7'h7B,7'h7C), 0,1,0));
        vecs.push_back(mk(0,0,1,0,0,7'h00, 1,1,254, n3(7'h7B,7'h7C,7'h7D), 0,1,0));
        // Test 2: PLAY hits on song 0
        vecs.push_back(mk(1,0,0,0,0,7'h00, 1,0,0, 21'h0,                0,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 6,3,3, n3(7'h0,7'h1,7'h2),   0,1,0));
        vecs.push_back(mk(0,0,0,0,1,7'h00, 3,0,3, n3(7'h0,7'h1,7'h2),   0,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 4,0,3, n3(7'h0,7'h1,7'h2),   0,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 1,1,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,0,0,0,1,7'h01, 2,0,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 6,1,5, n3(7'h2,7'h3,7'h4),   1,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 5,0,5, n3(7'h2,7'h3,7'h4),   1,1,0));
        vecs.push_back(mk(0,0,0,0,1,7'h02, 3,1,6, n3(7'h3,7'h4,7'h5),   2,1,0));
        // Test 4: pause mid-note freezes tick and streak
        vecs.push_back(mk(0,0,0,0,1,7'h03, 2,0,6, n3(7'h3,7'h4,7'h5),   2,1,0));
        vecs.push_back(mk(0,0,0,1,0,7'h00,20,0,6, n3(7'h3,7'h4,7'h5),   2,1,0));
        vecs.push_back(mk(0,0,0,0,1,7'h03, 1,0,6, n3(7'h3,7'h4,7'h5),   2,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 4,0,6, n3(7'h3,7'h4,7'h5),   2,1,0));
        vecs.push_back(mk(0,0,0,0,0,7'h00, 1,1,7, n3(7'h4,7'h5,7'h6),   3,1,0));
        // Test 3: LEARN advance after a held note, streak restart on mismatch
        vecs.push_back(mk(1,1,0,0,0,7'h00, 1,0,0, 21'h0,                0,1,0));
        vecs.push_back(mk(0,1,0,0,0,7'h00, 6,3,3, n3(7'h0,7'h1,7'h2),   0,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h00, 3,0,3, n3(7'h0,7'h1,7'h2),   0,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h00, 1,1,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h01, 1,0,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h05, 1,0,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h01, 3,0,4, n3(7'h1,7'h2,7'h3),   1,1,0));
        vecs.push_back(mk(0,1,0,0,1,7'h01, 1,1,5, n3(7'h2,7'h3,7'h4),   2,1,0));
        vecs.push_back(mk(0,1,0,0,0,7'h00,12,0,5, n3(7'h2,7'h3,7'h4),   2,1,0));

        // Reset state
        step(); step();
        chk("rst rom_addr", 32'(rom_bus.rom_addr), 32'd0);
        chk("rst notes", 32'(notes), 32'd0);
        chk("rst outputs", {28'd0, shifting_out, busy, finished, |hit_count}, 32'd0);
        rst_in = 1'b1;
        step();
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Test 5: FINISH note reached after two RUN shifts
        rom_mem[252] = 7'h7F;
        learn_mode = 1'b0; song_choice = 2'd1; input_valid = 1'b0; pause = 1'b0;
        start = 1'b1;
        run(7, sh);
        chk("fin prime notes", 32'(notes), 32'(n3(7'h7A,7'h7B,7'h7F)));
        run(8, sh);
        chk("fin shift1", 32'(notes), 32'(n3(7'h7B,7'h7F,7'h7D)));
        run(8, sh);
        chk("fin shift2 pulse", 32'(shifting_out), 32'd1);
        chk("fin shift2 notes", 32'(notes), 32'(n3(7'h7F,7'h7D,7'h7E)));
        chk("fin not yet", 32'(finished), 32'd0);
        step();
        chk("fin finished", 32'(finished), 32'd1);
        chk("fin busy", 32'(busy), 32'd0);
        input_valid = 1'b1; input_note = 7'h7F;
        run(10, sh);
        chk("fin frozen shifts", sh, 32'd0);
        chk("fin frozen notes", 32'(notes), 32'(n3(7'h7F,7'h7D,7'h7E)));
        chk("fin frozen addr", 32'(rom_bus.rom_addr), 32'd255);
        chk("fin no hit", 32'(hit_count), 32'd0);
        $display("seq finish: notes=%h addr=%0d fin=%0d", notes, rom_bus.rom_addr, finished);
        input_valid = 1'b0;
        start = 1'b1;
        run(1, sh);
        chk("fin restart addr", 32'(rom_bus.rom_addr), 32'd250);
        chk("fin restart flags", {30'd0, busy, finished}, 32'd2);
        run(6, sh);
        chk("fin reprime notes", 32'(notes), 32'(n3(7'h7A,7'h7B,7'h7F)));
        rom_mem[252] = 7'h7C;

        // Test 6: restart mid-PRIME, restart mid-RUN, async reset mid-RUN
        song_choice = 2'd2; start = 1'b1;
        run(4, sh);
        chk("midprime partial", 32'(notes), 32'h74);
        song_choice = 2'd0; start = 1'b1;
        run(1, sh);
        chk("midprime addr", 32'(rom_bus.rom_addr), 32'd0);
        chk("midprime notes", 32'(notes), 32'd0);
        chk("midprime pulse", 32'(shifting_out), 32'd0);
        run(6, sh);
        chk("midprime shifts", sh, 32'd3);
        chk("midprime reload", 32'(notes), 32'(n3(7'h0,7'h1,7'h2)));
        input_valid = 1'b1; input_note = 7'h00;
        run(3, sh);
        input_valid = 1'b0;
        run(5, sh);
        chk("midrun hits", 32'(hit_count), 32'd1);
        song_choice = 2'd1; start = 1'b1;
        run(1, sh);
        chk("midrun hit clr", 32'(hit_count), 32'd0);
        chk("midrun addr", 32'(rom_bus.rom_addr), 32'd250);
        chk("midrun notes", 32'(notes), 32'd0);
        $display("seq restart: addr=%0d notes=%h hits=%0d", rom_bus.rom_addr, notes, hit_count);
        run(8, sh);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async addr", 32'(rom_bus.rom_addr), 32'd0);
        chk("async notes", 32'(notes), 32'd0);
        chk("async flags", {29'd0, shifting_out, busy, finished}, 32'd0);
        step();
        rst_in = 1'b1;
        run(3, sh);
        chk("post rst idle", {30'd0, busy, finished}, 32'd0);
        chk("post rst addr", 32'(rom_bus.rom_addr), 32'd0);
        $display("seq reset: addr=%0d busy=%0d", rom_bus.rom_addr, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
